// File: rtl/store_buffer.sv
//------------------------------------------------------------------------------
// store_buffer
//
// Four-entry (DEPTH) circular FIFO of pending stores that sits between the
// CPU memory stage and a big-endian, byte-addressed data memory with a single
// combinational-read / clocked-write port.
//
// Stores are accepted without stalling the pipeline and drained to memory one
// per cycle whenever no load is using the port. Loads complete in the same
// cycle: either forwarded from the youngest matching buffered store or passed
// straight through to memory. A word load that overlaps a buffered byte store
// cannot be assembled from the buffer, so it stalls until that byte drains.
//
// Handshake: a store transfers on a rising edge where st_valid && st_ready;
// st_ready depends only on buffer occupancy, never on st_valid. A load has no
// ready; it completes in any cycle where ld_valid && !ld_stall, and the
// requester holds it unchanged while ld_stall is high.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   st_valid/st_ready           store request / buffer has room
//   st_byte, st_addr, st_data   store kind (1 = byte), byte address, data
//   ld_valid, ld_byte, ld_addr  load request, kind, byte address
//   ld_data, ld_stall           load result (byte loads zero-extended), stall
//   sb_empty                    no pending stores
//   mem_we, mem_byte, mem_addr, mem_wdata, mem_rdata   data memory port
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module store_buffer #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     st_valid,
    output logic                     st_ready,
    input  logic                     st_byte,
    input  logic [ADDRESS_WIDTH-1:0] st_addr,
    input  logic [DATA_WIDTH-1:0]    st_data,
    input  logic                     ld_valid,
    input  logic                     ld_byte,
    input  logic [ADDRESS_WIDTH-1:0] ld_addr,
    output logic [DATA_WIDTH-1:0]    ld_data,
    output logic                     ld_stall,
    output logic                     sb_empty,
    output logic                     mem_we,
    output logic                     mem_byte,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic [DATA_WIDTH-1:0]    mem_rdata
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NB    = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(NB);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    // Entry storage
    logic                     ent_byte [DEPTH];
    logic [ADDRESS_WIDTH-1:0] ent_addr [DEPTH];
    logic [DATA_WIDTH-1:0]    ent_data [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic push;
    logic pop;
    logic load_owns;

    // Forward search results
    logic                  hit;
    logic                  hit_byte;
    logic [DATA_WIDTH-1:0] hit_data;
    logic [PTR_W-1:0]      idx;
    logic                  word_same;
    logic                  exact_same;
    logic                  decides;
    logic [DATA_WIDTH-1:0] lane_shifted;

    assign st_ready = (count < FULL);
    assign sb_empty = (count == '0);
    assign push     = st_valid && st_ready;

    // Walk entries oldest to youngest; a later (younger) decisive entry
    // overrides an earlier one, so the youngest match wins. Only entries
    // present at the start of the cycle are visible (count, not push).
    always_comb begin
        hit        = 1'b0;
        hit_byte   = 1'b0;
        hit_data   = '0;
        idx        = '0;
        word_same  = 1'b0;
        exact_same = 1'b0;
        decides    = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            idx        = head + PTR_W'(k);
            word_same  = (ent_addr[idx][ADDRESS_WIDTH-1:OFF_W] ==
                          ld_addr[ADDRESS_WIDTH-1:OFF_W]);
            exact_same = (ent_addr[idx] == ld_addr);
            // A word load is decided by any entry in its word; a byte load
            // only by a word entry covering it or a byte entry at its address.
            if (ld_byte) begin
                decides = ent_byte[idx] ? exact_same : word_same;
            end else begin
                decides = word_same;
            end
            if ((CNT_W'(k) < count) && decides) begin
                hit      = 1'b1;
                hit_byte = ent_byte[idx];
                hit_data = ent_data[idx];
            end
        end
    end

    // A buffered byte cannot supply a whole word.
    assign ld_stall  = ld_valid && !ld_byte && hit && hit_byte;
    assign load_owns = ld_valid && !ld_stall;
    assign pop       = !load_owns && (count != '0);

    // Big-endian lane: offset 0 is the most significant byte, so the shift
    // (in bytes) is the bitwise inverse of the offset.
    assign lane_shifted = hit_data >> {~ld_addr[OFF_W-1:0], 3'b000};

    always_comb begin
        ld_data = mem_rdata;
        if (load_owns && hit) begin
            if (!ld_byte) begin
                ld_data = hit_data;
            end else if (hit_byte) begin
                ld_data = {{(DATA_WIDTH-8){1'b0}}, hit_data[7:0]};
            end else begin
                ld_data = {{(DATA_WIDTH-8){1'b0}}, lane_shifted[7:0]};
            end
        end
    end

    // Memory port: the load has priority; the head drains otherwise.
    assign mem_we    = pop;
    assign mem_addr  = pop ? ent_addr[head] : ld_addr;
    assign mem_byte  = pop ? ent_byte[head] : ld_byte;
    assign mem_wdata = ent_data[head];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Payload needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_byte[tail] <= st_byte;
            ent_addr[tail] <= st_addr;
            ent_data[tail] <= st_data;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
`timescale 1ns/1ps

module tb_store_buffer;

  // ---------------- clock / reset / DUT ----------------
  logic        clk;
  logic        rst_n;
  logic        st_valid;
  logic        st_ready;
  logic        st_byte;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        ld_valid;
  logic        ld_byte;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic        ld_stall;
  logic        sb_empty;
  logic        mem_we;
  logic        mem_byte;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  store_buffer #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_ready(st_ready), .st_byte(st_byte),
    .st_addr(st_addr), .st_data(st_data),
    .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_addr(ld_addr),
    .ld_data(ld_data), .ld_stall(ld_stall), .sb_empty(sb_empty),
    .mem_we(mem_we), .mem_byte(mem_byte), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // ---------------- data memory (big-endian, 1 KiB) ----------------
  logic [7:0] mem [0:1023];
  logic       mem_clear;

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
    end else if (mem_we) begin
      if (mem_byte) begin
        mem[mem_addr[9:0]] <= mem_wdata[7:0];
      end else begin
        mem[{mem_addr[9:2], 2'd0}] <= mem_wdata[31:24];
        mem[{mem_addr[9:2], 2'd1}] <= mem_wdata[23:16];
        mem[{mem_addr[9:2], 2'd2}] <= mem_wdata[15:8];
        mem[{mem_addr[9:2], 2'd3}] <= mem_wdata[7:0];
      end
    end
  end

  always_comb begin
    if (mem_byte) mem_rdata = {24'd0, mem[mem_addr[9:0]]};
    else mem_rdata = {mem[{mem_addr[9:2], 2'd0}], mem[{mem_addr[9:2], 2'd1}],
                      mem[{mem_addr[9:2], 2'd2}], mem[{mem_addr[9:2], 2'd3}]};
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {mem[{a[9:2], 2'd0}], mem[{a[9:2], 2'd1}], mem[{a[9:2], 2'd2}], mem[{a[9:2], 2'd3}]};
  endfunction

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        b;
    logic [31:0] a;
    logic [31:0] d;
  } st_t;

  st_t        q[$];
  logic [7:0] ref_mem [0:1023];
  logic [31:0] exp_q[$];

  logic        exp_st_ready;
  logic        exp_sb_empty;
  logic        exp_mem_we;
  logic        exp_ld_stall;
  logic [31:0] exp_ld_data;
  logic [31:0] exp_mem_addr;
  logic        exp_push;

  int n_total;
  int n_bad;

  function automatic logic [31:0] ref_read(input logic [31:0] a, input logic b);
    if (b) return {24'd0, ref_mem[a[9:0]]};
    return {ref_mem[{a[9:2], 2'd0}], ref_mem[{a[9:2], 2'd1}],
            ref_mem[{a[9:2], 2'd2}], ref_mem[{a[9:2], 2'd3}]};
  endfunction

  function automatic logic [7:0] be_byte(input logic [31:0] d, input logic [1:0] off);
    case (off)
      2'd0:    return d[31:24];
      2'd1:    return d[23:16];
      2'd2:    return d[15:8];
      default: return d[7:0];
    endcase
  endfunction

  // Expected outputs for the current inputs and pending-store list.
  task automatic model_eval();
    logic decided;
    decided      = 1'b0;
    exp_ld_stall = 1'b0;
    exp_ld_data  = ref_read(ld_addr, ld_byte);
    if (rst_n && ld_valid) begin
      for (int i = q.size() - 1; i >= 0 && !decided; i--) begin
        if (!ld_byte) begin
          if (q[i].a[31:2] == ld_addr[31:2]) begin
            decided = 1'b1;
            if (q[i].b) exp_ld_stall = 1'b1;
            else exp_ld_data = q[i].d;
          end
        end else if (q[i].b && q[i].a == ld_addr) begin
          decided     = 1'b1;
          exp_ld_data = {24'd0, q[i].d[7:0]};
        end else if (!q[i].b && q[i].a[31:2] == ld_addr[31:2]) begin
          decided     = 1'b1;
          exp_ld_data = {24'd0, be_byte(q[i].d, ld_addr[1:0])};
        end
      end
    end
    exp_mem_we   = rst_n && (q.size() > 0) && !(ld_valid && !exp_ld_stall);
    exp_mem_addr = (q.size() > 0) ? q[0].a : 32'd0;
    exp_st_ready = (q.size() < 4);
    exp_sb_empty = (q.size() == 0);
    exp_push     = rst_n && st_valid && exp_st_ready;
  endtask

  // Effects of the rising edge on the reference state.
  task automatic model_commit();
    st_t e;
    if (exp_mem_we) begin
      e = q.pop_front();
      if (e.b) begin
        ref_mem[e.a[9:0]] = e.d[7:0];
      end else begin
        ref_mem[{e.a[9:2], 2'd0}] = e.d[31:24];
        ref_mem[{e.a[9:2], 2'd1}] = e.d[23:16];
        ref_mem[{e.a[9:2], 2'd2}] = e.d[15:8];
        ref_mem[{e.a[9:2], 2'd3}] = e.d[7:0];
      end
    end
    if (exp_push) begin
      e.b = st_byte;
      e.a = st_addr;
      e.d = st_data;
      q.push_back(e);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Phase convention: inputs change 1 ns after a rising edge, outputs are
  // sampled 2 ns later, well clear of both edges.
  task automatic settle();
    #2;
    model_eval();
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic set_idle();
    st_valid = 1'b0;
    st_byte  = 1'b0;
    st_addr  = 32'd0;
    st_data  = 32'd0;
    ld_valid = 1'b0;
    ld_byte  = 1'b0;
    ld_addr  = 32'd0;
  endtask

  task automatic push_store(input logic b, input logic [31:0] a, input logic [31:0] d);
    st_valid = 1'b1;
    st_byte  = b;
    st_addr  = a;
    st_data  = d;
  endtask

  task automatic drain_all();
    set_idle();
    for (int i = 0; i < 8 && q.size() > 0; i++) tick();
    settle();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n     = 1'b0;
    mem_clear = 1'b1;
    set_idle();
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
    #2;
    n_total++;
    if (st_ready !== 1'b1 || sb_empty !== 1'b1 || mem_we !== 1'b0 || ld_stall !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: got rdy=%b empty=%b we=%b stall=%b want 1 1 0 0",
               st_ready, sb_empty, mem_we, ld_stall);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    mem_clear = 1'b0;
    rst_n     = 1'b1;
    settle();
    n_total++;
    if (sb_empty !== 1'b1 || mem_we !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release: got empty=%b we=%b want 1 0", sb_empty, mem_we);
    end
  endtask

  task automatic test_drain();
    logic [31:0] words [4];
    words[0] = 32'h11223344;
    words[1] = 32'h55667788;
    words[2] = 32'h99AABBCC;
    words[3] = 32'hDDEEFF00;
    set_idle();
    for (int k = 0; k < 6; k++) begin
      if (k < 4) push_store(1'b0, 32'h100 + 32'(4 * k), words[k]);
      else st_valid = 1'b0;
      settle();
      n_total++;
      if (mem_we !== ((k >= 1) && (k <= 4))) begin
        n_bad++;
        $display("FAIL drain_we_pattern k=%0d: got %b want %b", k, mem_we, (k >= 1) && (k <= 4));
      end
      if (exp_mem_we) begin
        n_total++;
        if (mem_addr !== exp_mem_addr) begin
          n_bad++;
          $display("FAIL drain_addr k=%0d: got %h want %h", k, mem_addr, exp_mem_addr);
        end
      end
      tick();
    end
    settle();
    n_total++;
    if (sb_empty !== 1'b1) begin
      n_bad++;
      $display("FAIL drain_empty: got %b want 1", sb_empty);
    end
    n_total++;
    if (mem[10'h100] !== 8'h11 || mem[10'h103] !== 8'h44) begin
      n_bad++;
      $display("FAIL drain_big_endian: got %h..%h want 11..44", mem[10'h100], mem[10'h103]);
    end
    for (int k = 0; k < 4; k++) exp_q.push_back(words[k]);
    for (int k = 0; k < 4; k++) begin
      logic [31:0] w;
      w = exp_q.pop_front();
      n_total++;
      if (mem_word(32'h100 + 32'(4 * k)) !== w) begin
        n_bad++;
        $display("FAIL drain_word%0d: got %h want %h", k, mem_word(32'h100 + 32'(4 * k)), w);
      end
    end
  endtask

  task automatic test_full_with_load();
    set_idle();
    ld_valid = 1'b1;
    ld_addr  = 32'h100;
    for (int k = 0; k < 6; k++) begin
      if (k < 5) push_store(1'b0, 32'h180 + 32'(4 * k), $urandom);
      else st_valid = 1'b0;
      settle();
      n_total++;
      if (st_ready !== (k < 4)) begin
        n_bad++;
        $display("FAIL full_ready k=%0d: got %b want %b", k, st_ready, k < 4);
      end
      n_total++;
      if (mem_we !== 1'b0) begin
        n_bad++;
        $display("FAIL full_no_drain k=%0d: got %b want 0", k, mem_we);
      end
      n_total++;
      if (ld_data !== 32'h11223344) begin
        n_bad++;
        $display("FAIL full_passthru k=%0d: got %h want 11223344", k, ld_data);
      end
      tick();
    end
    drain_all();
    n_total++;
    if (sb_empty !== 1'b1 || mem_word(32'h18C) !== ref_read(32'h18C, 1'b0)) begin
      n_bad++;
      $display("FAIL full_drained: got empty=%b word=%h want 1 %h",
               sb_empty, mem_word(32'h18C), ref_read(32'h18C, 1'b0));
    end
  endtask

  task automatic test_forward_byte();
    logic [7:0] tbl [4];
    tbl[0] = 8'hAA; tbl[1] = 8'hBB; tbl[2] = 8'hCC; tbl[3] = 8'hDD;
    set_idle();
    push_store(1'b0, 32'h200, 32'hAABBCCDD);
    tick();
    st_valid = 1'b0;
    ld_valid = 1'b1;
    ld_byte  = 1'b1;
    for (int off = 2; off < 6; off++) begin
      ld_addr = 32'h200 + 32'(off % 4);
      settle();
      n_total++;
      if (ld_data !== {24'd0, tbl[off % 4]} || ld_stall !== 1'b0 || mem_we !== 1'b0) begin
        n_bad++;
        $display("FAIL fwd_byte off=%0d: got data=%h stall=%b we=%b want %h 0 0",
                 off % 4, ld_data, ld_stall, mem_we, {24'd0, tbl[off % 4]});
      end
      tick();
    end
    drain_all();
  endtask

  task automatic test_byte_stall();
    int stalls;
    set_idle();
    push_store(1'b0, 32'h300, 32'h01020304);
    tick();
    drain_all();
    ld_valid = 1'b1;
    ld_addr  = 32'h100;
    push_store(1'b0, 32'h380, 32'h0BADF00D);
    tick();
    push_store(1'b1, 32'h301, 32'hFFFFFF5A);
    tick();
    st_valid = 1'b0;
    ld_addr  = 32'h300;
    stalls   = 0;
    for (int k = 0; k < 6; k++) begin
      settle();
      if (!ld_stall && !exp_ld_stall) break;
      stalls++;
      n_total++;
      if (ld_stall !== exp_ld_stall || mem_we !== 1'b1) begin
        n_bad++;
        $display("FAIL stall_cycle k=%0d: got stall=%b we=%b want %b 1", k, ld_stall, mem_we, exp_ld_stall);
      end
      tick();
    end
    n_total++;
    if (stalls != 2) begin
      n_bad++;
      $display("FAIL stall_length: got %0d want 2", stalls);
    end
    n_total++;
    if (ld_data !== 32'h015A0304 || ld_stall !== 1'b0 || mem_we !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_result: got data=%h stall=%b we=%b want 015a0304 0 0", ld_data, ld_stall, mem_we);
    end
    drain_all();
  endtask

  task automatic test_youngest_wins();
    set_idle();
    ld_valid = 1'b1;
    ld_addr  = 32'h100;
    push_store(1'b0, 32'h40, 32'h1);
    tick();
    push_store(1'b0, 32'h40, 32'h2);
    tick();
    st_valid = 1'b0;
    ld_addr  = 32'h40;
    settle();
    n_total++;
    if (ld_data !== 32'h2 || ld_stall !== 1'b0) begin
      n_bad++;
      $display("FAIL youngest_word: got %h stall=%b want 00000002 0", ld_data, ld_stall);
    end
    tick();
    ld_byte = 1'b1;
    ld_addr = 32'h43;
    settle();
    n_total++;
    if (ld_data !== 32'h2) begin
      n_bad++;
      $display("FAIL youngest_byte: got %h want 00000002", ld_data);
    end
    drain_all();
    n_total++;
    if (mem_word(32'h40) !== 32'h2) begin
      n_bad++;
      $display("FAIL youngest_mem: got %h want 00000002", mem_word(32'h40));
    end
  endtask

  task automatic test_reset_discard();
    set_idle();
    ld_valid = 1'b1;
    ld_addr  = 32'h100;
    for (int k = 0; k < 3; k++) begin
      push_store(1'b0, 32'h140 + 32'(4 * k), 32'hCAFE0001 + 32'(k));
      tick();
    end
    st_valid = 1'b0;
    ld_valid = 1'b0;
    settle();
    n_total++;
    if (sb_empty !== 1'b0 || mem_we !== 1'b1) begin
      n_bad++;
      $display("FAIL discard_pending: got empty=%b we=%b want 0 1", sb_empty, mem_we);
    end
    rst_n = 1'b0;
    q.delete();
    #1;
    n_total++;
    if (sb_empty !== 1'b1 || mem_we !== 1'b0 || st_ready !== 1'b1 || ld_stall !== 1'b0) begin
      n_bad++;
      $display("FAIL discard_immediate: got empty=%b we=%b rdy=%b stall=%b want 1 0 1 0",
               sb_empty, mem_we, st_ready, ld_stall);
    end
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    settle();
    for (int k = 0; k < 3; k++) begin
      n_total++;
      if (mem_word(32'h140 + 32'(4 * k)) !== 32'h0) begin
        n_bad++;
        $display("FAIL discard_mem%0d: got %h want 00000000", k, mem_word(32'h140 + 32'(4 * k)));
      end
    end
  endtask

  task automatic test_random();
    int diffs;
    set_idle();
    for (int c = 0; c < 400; c++) begin
      st_valid = ($urandom_range(0, 99) < 55);
      st_byte  = $urandom_range(0, 1);
      st_addr  = 32'($urandom_range(0, 31));
      if (!st_byte) st_addr[1:0] = 2'b00;
      st_data  = $urandom;
      ld_valid = ($urandom_range(0, 99) < 45);
      ld_byte  = $urandom_range(0, 1);
      ld_addr  = 32'($urandom_range(0, 31));
      if (!ld_byte) ld_addr[1:0] = 2'b00;
      settle();
      n_total++;
      if (st_ready !== exp_st_ready || sb_empty !== exp_sb_empty || mem_we !== exp_mem_we) begin
        n_bad++;
        $display("FAIL rand_ctrl c=%0d: got rdy=%b empty=%b we=%b want %b %b %b",
                 c, st_ready, sb_empty, mem_we, exp_st_ready, exp_sb_empty, exp_mem_we);
      end
      if (exp_mem_we) begin
        n_total++;
        if (mem_addr !== exp_mem_addr) begin
          n_bad++;
          $display("FAIL rand_drain_addr c=%0d: got %h want %h", c, mem_addr, exp_mem_addr);
        end
      end
      if (ld_valid) begin
        n_total++;
        if (ld_stall !== exp_ld_stall) begin
          n_bad++;
          $display("FAIL rand_stall c=%0d: got %b want %b", c, ld_stall, exp_ld_stall);
        end
        if (!exp_ld_stall) begin
          n_total++;
          if (ld_data !== exp_ld_data) begin
            n_bad++;
            $display("FAIL rand_ld_data c=%0d addr=%h byte=%b: got %h want %h",
                     c, ld_addr, ld_byte, ld_data, exp_ld_data);
          end
        end
      end
      tick();
    end
    drain_all();
    diffs = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) diffs++;
    n_total++;
    if (diffs != 0 || sb_empty !== 1'b1) begin
      n_bad++;
      $display("FAIL rand_mem_image: got %0d differing bytes empty=%b want 0 1", diffs, sb_empty);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_total = 0;
    n_bad   = 0;
    test_reset();
    test_drain();
    test_full_with_load();
    test_forward_byte();
    test_byte_stall();
    test_youngest_wins();
    test_reset_discard();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish by 1000000 ns want finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/store_buffer.md
# store_buffer

Four-entry FIFO store buffer between the CPU memory stage and the byte-addressed, big-endian data memory. It accepts word and byte stores without stalling the pipeline and drains them into memory through the memory's single write port whenever no load is using it. Loads are serviced in the same cycle, either forwarded from buffered stores or passed through to memory. The block owns the memory's address, write-enable and byte-select inputs.

## Interface
- ADDRESS_WIDTH, 32, byte address width
- DATA_WIDTH, 32, word width; byte lane is 8 bits
- DEPTH, 4, entry count; power of two, at least 2
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- st_valid  in  1  store request from memory stage
- st_ready  out  1  buffer can accept a store this cycle
- st_byte  in  1  1 = byte store (WriteData[7:0]), 0 = word store
- st_addr  in  ADDRESS_WIDTH  store byte address
- st_data  in  DATA_WIDTH  store data
- ld_valid  in  1  load request from memory stage
- ld_byte  in  1  1 = byte load, 0 = word load
- ld_addr  in  ADDRESS_WIDTH  load byte address
- ld_data  out  DATA_WIDTH  load result; byte loads are zero-extended
- ld_stall  out  1  load cannot complete this cycle; hold request
- sb_empty  out  1  no pending stores (fence/ecall drain indicator)
- mem_we  out  1  data memory write enable
- mem_byte  out  1  data memory ByteOp
- mem_addr  out  ADDRESS_WIDTH  data memory address
- mem_wdata  out  DATA_WIDTH  data memory WriteData
- mem_rdata  in  DATA_WIDTH  data memory ReadData (combinational)

## Operation
- Storage: circular FIFO with head/tail pointers (log2 DEPTH bits, wrap modulo DEPTH) and a count (log2 DEPTH + 1 bits). Each entry holds byte flag, address and data.
- Push when st_valid && st_ready. st_ready = (count < DEPTH). A store is never passed through in the same cycle it arrives.
- Forward search covers only entries present at the start of the cycle, searched youngest to oldest. Word match compares addr[31:2].
  - Word load: the youngest entry in the same word decides the result. A word entry forwards its data. A byte entry asserts ld_stall.
  - Byte load: the youngest entry that is either a word store in the same word or a byte store at the exact address decides the result.
    - Word entry: forward its byte in big-endian order. Offset 0 selects data[31:24], offset 3 selects data[7:0].
    - Byte entry: forward data[7:0].
    - In both cases the upper 24 bits are zero.
  - No match: ld_data = mem_rdata.
- Port arbitration:
  - Load owns the port when ld_valid && !ld_stall. Then mem_addr = ld_addr, mem_byte = ld_byte, mem_we = 0.
  - Otherwise, if count > 0, the head drains: mem_we = 1, mem_addr/mem_byte/mem_wdata taken from the head entry.
  - A forwarded load still occupies the port, so draining pauses.
- Pop head on every cycle mem_we = 1. Push and pop in the same cycle leave count unchanged. Push at full is impossible because st_ready = 0.
- ld_stall persists until the conflicting byte entry drains. The drain continues during the stall, which guarantees progress.
- sb_empty = (count == 0).
- With no valid request, ld_data = mem_rdata.

## Timing
- Reset (asynchronous, rst_n low):
  - count, head and tail go to 0.
  - All pending stores are discarded, including during an active drain.
  - Outputs while in reset: st_ready = 1, sb_empty = 1, mem_we = 0, ld_stall = 0.
- Load latency 0: ld_data and ld_stall are combinational from the request and buffer state.
- A store pushed at edge k drives mem_we in cycle k+1 at the earliest, when it is at the head and no load owns the port. It is written to memory at edge k+1.
- Drain throughput: one store per cycle while ld_valid is low.
- st_ready deasserts in the cycle after the edge at which count reaches DEPTH. It reasserts in the cycle after the first pop.

## Test plan
- Reset, then 4 word stores with ld_valid = 0 throughout:
  - required: mem_we pulses on 4 consecutive cycles starting the cycle after the first push;
  - required: memory holds each word big-endian (e.g. 0x11223344 at 0x100 → byte 0x100 = 0x11);
  - required: sb_empty returns to 1.
- Hold ld_valid = 1 to a non-matching address while pushing 5 stores:
  - required: st_ready = 0 after the 4th push;
  - required: mem_we stays 0 throughout;
  - required: ld_data = mem_rdata.
- Word store 0xAABBCCDD @0x200, then in the next cycle byte load @0x202:
  - required: ld_data = 0x000000CC forwarded, ld_stall = 0, mem_we = 0.
- Byte store 0x5A @0x301, then word load @0x300:
  - required: ld_stall = 1 until that entry drains;
  - required: ld_data then equals the memory word with byte 1 = 0x5A.
- Word store 0x1 @0x40, then word store 0x2 @0x40, then word load @0x40:
  - required: ld_data = 0x00000002 (youngest wins).
- Assert rst_n low with 3 pending stores:
  - required: sb_empty = 1 and mem_we = 0 immediately;
  - required: none of the 3 pending stores reaches memory.
